gpu_frame_sequencer: RTL and testbench

Parametrised frame/pass controller for the GPU pipeline, sitting between the rasterizer, the N colorloop channels, the Z-buffer and the frame-buffer transfer unit. It replaces the fixed combinational glue with registered control: it flips the wireframe buffer on triangle completion, launches and tracks N shading channels, and sequences the frame flip and transfer start. It also optionally sweeps the Z-buffer clear and flags overruns and hung channels.

---
 rtl/gpu_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_gpu_frame_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_frame_sequencer.sv
// gpu_frame_sequencer: registered frame/pass controller. It flips the wireframe
// buffer per triangle, launches and tracks the shading channels, then flips the
// frame buffer, starts the transfer and optionally sweeps the Z-buffer clear.
module gpu_frame_sequencer #(
  parameter int NUM_CH    = 4,
  parameter int ZB_DEPTH  = 19200,
  parameter int ZB_ADDR_W = 15,
  parameter int LAYER_W   = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 ras_done,
  input  logic [NUM_CH-1:0]    ch_done,
  input  logic                 new_frame,
  input  logic                 transfer_done,
  input  logic                 clear_en,
  output logic                 ras_hold,
  output logic                 wf_flip,
  output logic                 color_en,
  output logic                 cf_done,
  output logic                 fb_flip,
  output logic                 transfer_start,
  output logic                 zb_clr_we,
  output logic [ZB_ADDR_W-1:0] zb_clr_addr,
  output logic [LAYER_W-1:0]   zb_clr_data,
  output logic [15:0]          frame_count,
  output logic                 overrun,
  output logic                 timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLIP, S_LAUNCH, S_SHADE, S_FRAME, S_CLEAR
  } state_t;

  localparam logic [ZB_ADDR_W-1:0] ZB_LAST = ZB_ADDR_W'(ZB_DEPTH - 1);
  // Watchdog value in the last SHADE cycle: the increment taken there reaches all ones.
  localparam logic [TIMEOUT_W-1:0] WD_PRE  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t                 state_q, state_d;
  logic                   ras_pend_q, ras_pend_d;
  logic                   frm_pend_q, frm_pend_d;
  logic                   xfer_busy_q, xfer_busy_d;
  logic [NUM_CH-1:0]      mask_q, mask_d;
  logic [TIMEOUT_W-1:0]   wd_q, wd_d;
  logic [ZB_ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]            fc_q, fc_d;
  logic                   cf_done_q, cf_done_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;

  // Next-state, pending-flag, counter and sticky-status logic.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    wd_d        = wd_q;
    addr_d      = addr_q;
    fc_d        = fc_q;
    cf_done_d   = 1'b0;
    timeout_d   = timeout_q;
    // A pulse that lands on an already-set pending flag is dropped and flagged.
    overrun_d   = overrun_q | (ras_done & ras_pend_q) | (new_frame & frm_pend_q);
    case (state_q)
      S_IDLE: begin
        if (ras_pend_q || ras_done) begin
          state_d = S_FLIP;
        end else if ((frm_pend_q || new_frame) && !xfer_busy_q) begin
          state_d = S_FRAME;
          fc_d    = fc_q + 16'd1;
        end
      end
      S_FLIP:   state_d = S_LAUNCH;
      S_LAUNCH: begin
        mask_d  = '0;
        wd_d    = '0;
        state_d = S_SHADE;
      end
      S_SHADE: begin
        mask_d = mask_q | ch_done;
        wd_d   = wd_q + TIMEOUT_W'(1);
        if (&(mask_q | ch_done)) begin
          state_d   = S_IDLE;
          cf_done_d = 1'b1;
        end else if (wd_q == WD_PRE) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_FRAME:  state_d = clear_en ? S_CLEAR : S_IDLE;
      S_CLEAR: begin
        if (addr_q == ZB_LAST) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + ZB_ADDR_W'(1);
        end
      end
      default:  state_d = S_IDLE;
    endcase

    ras_pend_d = ras_pend_q;
    if (state_d == S_FLIP)   ras_pend_d = 1'b0;
    else if (ras_done)       ras_pend_d = 1'b1;

    frm_pend_d = frm_pend_q;
    if (state_d == S_FRAME)  frm_pend_d = 1'b0;
    else if (new_frame)      frm_pend_d = 1'b1;

    // Transfer start wins over a coincident transfer_done.
    xfer_busy_d = xfer_busy_q;
    if (state_q == S_FRAME)  xfer_busy_d = 1'b1;
    else if (transfer_done)  xfer_busy_d = 1'b0;
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q     <= S_IDLE;
      ras_pend_q  <= 1'b0;
      frm_pend_q  <= 1'b0;
      xfer_busy_q <= 1'b0;
      mask_q      <= '0;
      wd_q        <= '0;
      addr_q      <= '0;
      fc_q        <= '0;
      cf_done_q   <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ras_pend_q  <= ras_pend_d;
      frm_pend_q  <= frm_pend_d;
      xfer_busy_q <= xfer_busy_d;
      mask_q      <= mask_d;
      wd_q        <= wd_d;
      addr_q      <= addr_d;
      fc_q        <= fc_d;
      cf_done_q   <= cf_done_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  // Outputs decoded from registers. The rasterizer stays held through the
  // cf_done cycle so a new triangle cannot race the completion pulse.
  always_comb begin
    ras_hold       = (state_q != S_IDLE) | ras_pend_q | cf_done_q;
    wf_flip        = (state_q == S_FLIP);
    color_en       = (state_q == S_LAUNCH);
    cf_done        = cf_done_q;
    fb_flip        = (state_q == S_FRAME);
    transfer_start = (state_q == S_FRAME);
    zb_clr_we      = (state_q == S_CLEAR);
    zb_clr_addr    = addr_q;
    // Clear value is all ones while writing; idle bus reads zero.
    zb_clr_data    = {LAYER_W{zb_clr_we}};
    frame_count    = fc_q;
    overrun        = overrun_q;
    timeout        = timeout_q;
  end

endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// Directed testbench for gpu_frame_sequencer (NUM_CH=4, ZB_DEPTH=16, TIMEOUT_W=6).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_gpu_frame_sequencer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        ras_done = 1'b0;
  logic [3:0]  ch_done = 4'd0;
  logic        new_frame = 1'b0;
  logic        transfer_done = 1'b0;
  logic        clear_en = 1'b0;
  logic        ras_hold, wf_flip, color_en, cf_done, fb_flip, transfer_start, zb_clr_we;
  logic [4:0]  zb_clr_addr;
  logic [7:0]  zb_clr_data;
  logic [15:0] frame_count;
  logic        overrun, timeout;

  int n_vec = 0;
  int n_err = 0;

  gpu_frame_sequencer #(
    .NUM_CH(4), .ZB_DEPTH(16), .ZB_ADDR_W(5), .LAYER_W(8), .TIMEOUT_W(6)
  ) dut (
    .clk(clk), .n_rst(n_rst), .ras_done(ras_done), .ch_done(ch_done),
    .new_frame(new_frame), .transfer_done(transfer_done), .clear_en(clear_en),
    .ras_hold(ras_hold), .wf_flip(wf_flip), .color_en(color_en), .cf_done(cf_done),
    .fb_flip(fb_flip), .transfer_start(transfer_start), .zb_clr_we(zb_clr_we),
    .zb_clr_addr(zb_clr_addr), .zb_clr_data(zb_clr_data), .frame_count(frame_count),
    .overrun(overrun), .timeout(timeout)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    ras_done = 1'b0;
    ch_done = 4'd0;
    new_frame = 1'b0;
    transfer_done = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    clear_en = 1'b0;
    cyc();
    cyc();
    n_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [29:0] act;
    do_reset();
    @(negedge clk);
    act = {ras_hold, wf_flip, color_en, cf_done, fb_flip, transfer_start, zb_clr_we,
           zb_clr_addr, overrun, timeout, frame_count};
    n_vec++;
    if (act !== 30'd0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0", act);
    end
    n_vec++;
    if (zb_clr_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_zb_data got=%h exp=00", zb_clr_data);
    end
  endtask

  // ras_done at k0; channel pulses at k4, k5, k7 -> cf_done at k8 only.
  task automatic test_shade();
    logic e_wf, e_ce, e_cf, e_rh;
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) cyc();
      ras_done = (k == 0);
      ch_done = (k == 4) ? 4'b0001 : (k == 5) ? 4'b0110 : (k == 7) ? 4'b1000 : 4'b0000;
      e_wf = (k == 1);
      e_ce = (k == 2);
      e_cf = (k == 8);
      e_rh = (k >= 1 && k <= 8);
      @(negedge clk);
      n_vec++;
      if (wf_flip !== e_wf) begin n_err++; $display("FAIL shade_wf_flip k=%0d got=%b exp=%b", k, wf_flip, e_wf); end
      n_vec++;
      if (color_en !== e_ce) begin n_err++; $display("FAIL shade_color_en k=%0d got=%b exp=%b", k, color_en, e_ce); end
      n_vec++;
      if (cf_done !== e_cf) begin n_err++; $display("FAIL shade_cf_done k=%0d got=%b exp=%b", k, cf_done, e_cf); end
      n_vec++;
      if (ras_hold !== e_rh) begin n_err++; $display("FAIL shade_ras_hold k=%0d got=%b exp=%b", k, ras_hold, e_rh); end
    end
  endtask

  // new_frame at k0, clear_en only in the FRAME cycle, ras_done during CLEAR.
  task automatic test_clear();
    logic e_fb, e_we, e_wf, e_ce, e_cf, e_rh;
    logic [4:0]  e_addr;
    logic [7:0]  e_data;
    logic [15:0] e_fc;
    do_reset();
    for (int k = 0; k <= 23; k++) begin
      if (k > 0) cyc();
      new_frame = (k == 0);
      clear_en = (k == 1);
      ras_done = (k == 10);
      ch_done = (k == 21) ? 4'b1111 : 4'b0000;
      e_fb = (k == 1);
      e_we = (k >= 2 && k <= 17);
      e_addr = e_we ? 5'(k - 2) : 5'd0;
      e_data = e_we ? 8'hFF : 8'h00;
      e_fc = (k >= 1) ? 16'd1 : 16'd0;
      e_wf = (k == 19);
      e_ce = (k == 20);
      e_cf = (k == 22);
      e_rh = (k >= 1 && k <= 22);
      @(negedge clk);
      n_vec++;
      if ({fb_flip, transfer_start} !== {e_fb, e_fb}) begin n_err++; $display("FAIL clear_flip_start k=%0d got=%b%b exp=%b%b", k, fb_flip, transfer_start, e_fb, e_fb); end
      n_vec++;
      if (zb_clr_we !== e_we) begin n_err++; $display("FAIL clear_we k=%0d got=%b exp=%b", k, zb_clr_we, e_we); end
      n_vec++;
      if (zb_clr_addr !== e_addr) begin n_err++; $display("FAIL clear_addr k=%0d got=%0d exp=%0d", k, zb_clr_addr, e_addr); end
      n_vec++;
      if (zb_clr_data !== e_data) begin n_err++; $display("FAIL clear_data k=%0d got=%h exp=%h", k, zb_clr_data, e_data); end
      n_vec++;
      if (frame_count !== e_fc) begin n_err++; $display("FAIL clear_frame_count k=%0d got=%0d exp=%0d", k, frame_count, e_fc); end
      n_vec++;
      if ({wf_flip, color_en, cf_done} !== {e_wf, e_ce, e_cf}) begin n_err++; $display("FAIL clear_pending_ras k=%0d got=%b%b%b exp=%b%b%b", k, wf_flip, color_en, cf_done, e_wf, e_ce, e_cf); end
      n_vec++;
      if (ras_hold !== e_rh) begin n_err++; $display("FAIL clear_ras_hold k=%0d got=%b exp=%b", k, ras_hold, e_rh); end
      n_vec++;
      if (overrun !== 1'b0) begin n_err++; $display("FAIL clear_overrun k=%0d got=%b exp=0", k, overrun); end
    end
  endtask

  // Frame requests while the transfer is busy; third request overruns.
  task automatic test_xfer_busy();
    logic e_fb, e_ov, e_rh;
    int   late_flips;
    late_flips = 0;
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) cyc();
      new_frame = (k == 0 || k == 3 || k == 6);
      transfer_done = (k == 9);
      e_fb = (k == 1);
      e_ov = (k >= 7);
      e_rh = (k == 1);
      @(negedge clk);
      if (k <= 9) begin
        n_vec++;
        if (fb_flip !== e_fb) begin n_err++; $display("FAIL xfer_fb_flip k=%0d got=%b exp=%b", k, fb_flip, e_fb); end
        n_vec++;
        if (ras_hold !== e_rh) begin n_err++; $display("FAIL xfer_ras_hold k=%0d got=%b exp=%b", k, ras_hold, e_rh); end
      end else if (k <= 11) begin
        if (fb_flip === 1'b1) late_flips++;
      end
      n_vec++;
      if (overrun !== e_ov) begin n_err++; $display("FAIL xfer_overrun k=%0d got=%b exp=%b", k, overrun, e_ov); end
      if (k == 5) begin
        n_vec++;
        if (frame_count !== 16'd1) begin n_err++; $display("FAIL xfer_count_first got=%0d exp=1", frame_count); end
      end
    end
    n_vec++;
    if (late_flips !== 1) begin n_err++; $display("FAIL xfer_deferred_flip got=%0d flips exp=1", late_flips); end
    n_vec++;
    if (frame_count !== 16'd2) begin n_err++; $display("FAIL xfer_count_second got=%0d exp=2", frame_count); end
  endtask

  // ras_done and new_frame together: triangle first, frame right after cf_done.
  task automatic test_priority();
    logic e_wf, e_ce, e_cf, e_fb, e_rh;
    logic [15:0] e_fc;
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) cyc();
      ras_done = (k == 0);
      new_frame = (k == 0);
      ch_done = (k == 3) ? 4'b1111 : 4'b0000;
      e_wf = (k == 1);
      e_ce = (k == 2);
      e_cf = (k == 4);
      e_fb = (k == 5);
      e_rh = (k >= 1 && k <= 5);
      e_fc = (k >= 5) ? 16'd1 : 16'd0;
      @(negedge clk);
      n_vec++;
      if ({wf_flip, color_en, cf_done, fb_flip} !== {e_wf, e_ce, e_cf, e_fb}) begin
        n_err++;
        $display("FAIL prio_seq k=%0d got=%b%b%b%b exp=%b%b%b%b", k, wf_flip, color_en, cf_done, fb_flip, e_wf, e_ce, e_cf, e_fb);
      end
      n_vec++;
      if (ras_hold !== e_rh) begin n_err++; $display("FAIL prio_ras_hold k=%0d got=%b exp=%b", k, ras_hold, e_rh); end
      n_vec++;
      if (frame_count !== e_fc) begin n_err++; $display("FAIL prio_frame_count k=%0d got=%0d exp=%0d", k, frame_count, e_fc); end
    end
  endtask

  // Channel 2 never finishes: 63 SHADE cycles, then timeout without cf_done.
  task automatic test_timeout();
    logic e_to, e_rh;
    do_reset();
    for (int k = 0; k <= 67; k++) begin
      if (k > 0) cyc();
      ras_done = (k == 0);
      ch_done = (k >= 3) ? 4'b1011 : 4'b0000;
      e_to = (k >= 66);
      e_rh = (k >= 1 && k <= 65);
      @(negedge clk);
      n_vec++;
      if (timeout !== e_to) begin n_err++; $display("FAIL timeout_flag k=%0d got=%b exp=%b", k, timeout, e_to); end
      n_vec++;
      if (ras_hold !== e_rh) begin n_err++; $display("FAIL timeout_ras_hold k=%0d got=%b exp=%b", k, ras_hold, e_rh); end
      n_vec++;
      if (cf_done !== 1'b0) begin n_err++; $display("FAIL timeout_cf_done k=%0d got=%b exp=0", k, cf_done); end
    end
  endtask

  // Second run after the timeout: reset lands mid-SHADE and clears everything.
  task automatic test_reset_mid();
    logic [29:0] act;
    for (int k = 0; k <= 12; k++) begin
      cyc();
      ras_done = (k == 0);
      if (k == 10) n_rst = 1'b1;
      if (k == 12) n_rst = 1'b0;
      @(negedge clk);
      if (k == 10) begin
        n_vec++;
        if ({ras_hold, timeout} !== 2'b11) begin n_err++; $display("FAIL midrst_before got=%b%b exp=11", ras_hold, timeout); end
      end
      if (k >= 11) begin
        act = {ras_hold, wf_flip, color_en, cf_done, fb_flip, transfer_start, zb_clr_we,
               zb_clr_addr, overrun, timeout, frame_count};
        n_vec++;
        if (act !== 30'd0) begin n_err++; $display("FAIL midrst_outputs k=%0d got=%h exp=0", k, act); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_shade();
    test_clear();
    test_xfer_busy();
    test_priority();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
